// File: rtl/fixed_divider.sv
// fixed_divider: sequential restoring signed Q-format divider with saturation
module fixed_divider #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] z,
    output logic         ov
);
    localparam int W = N + Q;
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] ITER_END = CW'(W);
    localparam logic [CW-1:0] LAST = CW'(W + 1);
    localparam logic [W-1:0] QLIM = W'(1) << (N - 1);
    localparam logic [N-1:0] ZMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] ZMIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   dvd, qm;
    logic [N-1:0]   ay;
    logic [N:0]     rem;
    logic [N+1:0]   rem_sh;
    logic [CW-1:0]  cnt;
    logic           neg, dz, ge, ov_nx;
    logic [N-1:0]   ax_abs, ay_abs, z_nx;

    // Magnitudes of the operands; the most negative value maps onto 2^(N-1)
    always_comb begin
        ax_abs = x[N-1] ? -x : x;
        ay_abs = y[N-1] ? -y : y;
        rem_sh = {rem, dvd[W-1]};
        ge     = rem_sh >= {2'b0, ay};
        ov_nx  = dz | (!neg && qm >= QLIM) | (neg && qm > QLIM);
        z_nx   = ov_nx ? (neg ? ZMIN : ZMAX) : neg ? -qm[N-1:0] : qm[N-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        done     = state == DONE;
        case (state)
            IDLE:    state_nx = start ? CALC : IDLE;
            CALC:    state_nx = (cnt == LAST) ? DONE : CALC;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, one restoring step per CALC cycle, result registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd <= '0;
            qm  <= '0;
            ay  <= '0;
            rem <= '0;
            cnt <= '0;
            neg <= 1'b0;
            dz  <= 1'b0;
            z   <= '0;
            ov  <= 1'b0;
        end else if (state == IDLE && start) begin
            dvd <= {ax_abs, {Q{1'b0}}};
            ay  <= ay_abs;
            neg <= x[N-1] ^ y[N-1];
            dz  <= y == '0;
            qm  <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (cnt < ITER_END) begin
                rem <= ge ? (N+1)'(rem_sh - {2'b0, ay}) : rem_sh[N:0];
                qm  <= {qm[W-2:0], ge};
                dvd <= dvd << 1;
            end
            if (cnt == LAST) begin
                z  <= z_nx;
                ov <= ov_nx;
            end
        end
    end
endmodule

// File: doc/fixed_divider.md
Name: fixed_divider

Overview:
- Sequential signed fixed-point divider, the inverse companion of the team's combinational saturating fixed-point multiplier.
- Computes z = (x << Q) / y in two's-complement Q-format. The result is truncated toward zero and saturated to N bits, with an overflow flag.
- Uses a multi-cycle restoring algorithm, one quotient bit per clock, so wide operands close timing in the SEA FPGA control loop.
- Used for gain normalisation and stiffness/force scaling.

Parameters:
- N, 32: operand and result width, in bits.
- Q, 16: number of fractional bits, shared by x, y and z.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- x  input  N  signed dividend, Q-format; sampled when start is accepted.
- y  input  N  signed divisor, Q-format; sampled when start is accepted.
- busy  output  1  high from the cycle after acceptance through the DONE cycle.
- done  output  1  one-cycle pulse; z and ov are valid in this cycle.
- z  output  N  signed quotient, Q-format; held until the next done.
- ov  output  1  set when the result saturated or the divisor was zero; held with z.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - busy=0, done=0, z=0, ov=0; all internal registers are cleared.
  - Reset mid-operation aborts the division; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge accepts the request and moves to CALC.
  - On acceptance: latch |x| and |y| as N-bit unsigned values (|-2^(N-1)| = 2^(N-1) is representable). Latch neg = x[N-1]^y[N-1] and the flag dz = (y==0).
  - Clear the iteration counter and partial remainder.
- CALC:
  - Runs exactly N+Q iterations.
  - The dividend magnitude is extended to N+Q bits as |x|<<Q and its bits are shifted in MSB-first.
  - Each iteration: rem = {rem, next bit}. If rem >= |y|, subtract |y| and shift in quotient bit 1; otherwise shift in 0.
  - The remainder is N+1 bits wide.
  - After the last iteration, move to DONE.
- DONE (one cycle): done=1, busy=1; then return to IDLE.
- Output update: z and ov are registered on the CALC→DONE transition and hold until the next DONE.
- Latency: start accepted at edge k → done high in the cycle after edge k+N+Q+1, i.e. a fixed N+Q+2 cycles. Divide-by-zero takes the same latency.
- start handling:
  - start while busy is ignored; no queuing.
  - start in the same cycle done is high is ignored, since the state is DONE.
  - A back-to-back request can be accepted in the cycle after done.
- Result rules (quotient magnitude qm is N+Q bits unsigned):
  - dz=1: ov=1. z = 2^(N-1)-1 if x>=0, z = -2^(N-1) if x<0.
  - neg=0 and qm > 2^(N-1)-1: ov=1, z = 2^(N-1)-1.
  - neg=1 and qm > 2^(N-1): ov=1, z = -2^(N-1).
  - Otherwise ov=0, and z = qm (neg=0) or -qm (neg=1), truncated to N bits. A result of exactly -2^(N-1) is legal with ov=0.
  - x=0 with y≠0: z=0, ov=0; the sign is not applied.
- Truncation: always toward zero, since the algorithm divides magnitudes. No rounding.
- x and y may change freely after acceptance without affecting the result.

Test Plan (N=32, Q=16):
- Reset: assert rst_n=0 during CALC → busy=0, done=0, z=0, ov=0 immediately. Release reset, then start with x=0x0003_0000, y=0x0002_0000 → done exactly 50 cycles after acceptance, z=0x0001_8000 (1.5), ov=0.
- Sign and truncation: x=0xFFFF_0000 (-1.0), y=0x0003_0000 → z=0xFFFF_AAAB, ov=0. Swap the signs → z=0xFFFF_AAAB. Both negative → z=0x0000_5555.
- Saturation:
  - x=0x7FFF_FFFF, y=0x0000_0001 → z=0x7FFF_FFFF, ov=1.
  - x=0x8000_0000, y=0xFFFF_0000 (-1.0) → z=0x7FFF_FFFF, ov=1.
  - x=0x8000_0000, y=0x0001_0000 → z=0x8000_0000, ov=0.
- Divide by zero: x=0xFFFB_0000, y=0 → z=0x8000_0000, ov=1. x=0x0005_0000, y=0 → z=0x7FFF_FFFF, ov=1. Latency is 50 cycles in both cases.
- Handshake:
  - Pulse start again mid-CALC and in the DONE cycle with different operands → ignored; the first result is unchanged.
  - start in the cycle after done → accepted.
  - z and ov hold until the next done.
- Random regression: 10k random x and y against a reference model of trunc((x·2^16)/y) with saturation → exact match of z, ov and latency.
